// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle processor.
// Sequences PC, memory, IR, register file and ALU muxes over
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles with a mem_ready handshake.
// Optional feature macro: ADDI_EN (adds ADDI_EX/ADDI_WB states for OP_ADDI).
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
`ifdef ADDI_EN
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
`else
    S_JUMP     = 4'd9
`endif
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;
  logic   w_decode_illegal;

  assign state      = r_state;
  assign illegal_op = r_illegal;

  // State register and the registered one-cycle illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_decode_illegal;
    end
  end

  // Next-state selection; opcode matters only in DECODE and MEM_ADDR.
  always_comb begin
    w_next_state     = S_FETCH;
    w_decode_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      w_next_state = S_ADDI_EX;
`endif
          default: begin
            w_next_state     = S_FETCH;
            w_decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          w_next_state = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          w_next_state = S_MEM_WR;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          w_next_state = S_MEM_WB;
        end else begin
          w_next_state = S_MEM_RD;
        end
      end
      S_MEM_WB: w_next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_EXEC:    w_next_state = S_R_WB;
      S_R_WB:    w_next_state = S_FETCH;
      S_BRANCH:  w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
`ifdef ADDI_EN
      S_ADDI_EX: w_next_state = S_ADDI_WB;
      S_ADDI_WB: w_next_state = S_FETCH;
`endif
      // Unused encodings recover to FETCH.
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH also looks at mem_ready to gate IR/PC loads.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef ADDI_EN
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected state and
// output vectors are queued as stimulus is driven and compared on the
// falling edge. Define ADDI_EN for both RTL and bench to cover ADDI.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic [20:0] sb_q [$];
  logic [20:0] obs;
  logic [20:0] exp_v;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, illegal_op, pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source};

  // Reference output table written from the state descriptions.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic mr, input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa} = 10'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      4'd9:  begin pw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: rw = 1'b1;
      default: pw = 1'b0;
    endcase
    return {st, ill, pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(exp_vec(4'd0, 1'b0, 1'b0));
    @(negedge clk);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset got %h want %h", obs, exp_v);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(exp_vec(4'd0, 1'b0, 1'b0));
    @(negedge clk);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_release got %h want %h", obs, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [3:0] st [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = OP_RTYPE;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      sb_q.push_back(exp_vec(st[i], 1'b1, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rtype cyc %0d got %h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] st [8];
    logic       mr [8];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      sb_q.push_back(exp_vec(st[i], mr[i], 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lw cyc %0d got %h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [3:0] st [6];
    logic       mr [6];
    st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      sb_q.push_back(exp_vec(st[i], mr[i], 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sw cyc %0d got %h want %h", i, obs, exp_v);
      end
      checks++;
      if ((mem_read & mem_write) !== 1'b0) begin
        errors++;
        $display("FAIL sw_rd_wr cyc %0d got %b want 0", i, mem_read & mem_write);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st [6];
    logic [5:0] op [6];
    st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    op = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    for (int i = 0; i < 6; i++) begin
      opcode = op[i];
      mem_ready = 1'b1;
      sb_q.push_back(exp_vec(st[i], 1'b1, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL beq_j cyc %0d got %h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_addi();
    logic [3:0] st [8];
    logic       mr [8];
    logic       il [8];
    logic [5:0] op [8];
`ifdef ADDI_EN
    st = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd10, 4'd11};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    il = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    st = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    il = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    op = '{OP_BAD, OP_BAD, OP_BAD, OP_BAD, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    for (int i = 0; i < 8; i++) begin
      opcode = op[i];
      mem_ready = mr[i];
      sb_q.push_back(exp_vec(st[i], mr[i], il[i]));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL illegal_addi cyc %0d got %h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [6];
    logic       mr [6];
    logic       rs [6];
    st = '{4'd0, 4'd1, 4'd6, 4'd0, 4'd0, 4'd0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_RTYPE;
    for (int i = 0; i < 6; i++) begin
      rst_n = rs[i];
      mem_ready = mr[i];
      sb_q.push_back(exp_vec(st[i], mr[i], 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_back_to_back();
    test_illegal_addi();
    test_reset_mid();
    test_rtype();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
